fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
- Output stage directly downstream of the final radix-2 FFT stage.
- Captures the eight parallel complex results (real/imag, natural order 0..7) of one transform in a single cycle.
- Streams them one complex sample per beat over a valid/ready interface to the system output port.
- Decouples the free-running butterfly pipeline from a back-pressuring consumer; reports dropped frames.

Parameters:
- N, 3, data width exponent; every real/imag bus is 2**N bits wide (8 by default), matching the FFT stages.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- in_0_r..in_7_r  input  2**N each  real parts of frame samples 0..7 from final stage
- in_0_i..in_7_i  input  2**N each  imaginary parts of frame samples 0..7
- in_valid  input  1  frame on in_* is valid this cycle
- in_ready  output  1  serializer can capture a frame this cycle
- out_r  output  2**N  real part of current sample
- out_i  output  2**N  imaginary part of current sample
- out_idx  output  3  bin index of current sample (0..7)
- out_last  output  1  high with sample 7
- out_valid  output  1  out_r/out_i/out_idx/out_last valid
- out_ready  input  1  consumer accepts current beat
- drop  output  1  sticky: a frame was offered while in_ready was low

Behaviour:
- Reset (rst low at a clock edge):
  - state IDLE, idx 0, buffers cleared.
  - out_valid 0, out_r 0, out_i 0, out_idx 0, out_last 0, drop 0.
  - in_ready is 0 while rst is low.
- in_ready is combinational: rst & (state==IDLE). Optional feature changes this.
- Capture: in_valid & in_ready at an edge latches all 16 buses into the frame buffer as a bit-exact copy; no arithmetic or rescaling.
- FSM, states IDLE and SEND:
  - IDLE, capture: -> SEND, idx=0.
  - SEND, beat accepted (out_valid & out_ready), idx<7: idx+1.
  - SEND, beat accepted, idx==7: -> IDLE, idx=0.
  - SEND, out_ready low: hold. out_r, out_i, out_idx and out_last stay stable and out_valid stays 1.
- Output timing:
  - out_valid=1 exactly when state==SEND.
  - out_r/out_i = buffer[idx], out_idx=idx, out_last=(idx==7). All are registered values and change only at edges.
  - Latency: capture at edge k gives sample 0 on outputs in the cycle after edge k.
- Throughput without the optional feature:
  - 8 beats plus 1 IDLE capture cycle per frame, i.e. minimum 9 cycles/frame with out_ready held high.
- Drop:
  - in_valid & !in_ready at an edge with rst high sets drop. The frame is discarded and the buffer is untouched.
  - drop clears only on reset.
- Reset mid-frame: current frame is abandoned, no further beats, and outputs return to reset values on that edge.
- out_ready high while out_valid low is ignored.

Optional Feature:
- Macro: FFT_OUT_DBUF_EN. Adds a one-frame shadow buffer with a full flag.
- With the macro defined:
  - in_ready = rst & !shadow_full.
  - In IDLE, a capture goes to the main buffer (-> SEND).
  - In SEND, a capture goes to the shadow buffer and sets shadow_full.
  - On acceptance of the idx==7 beat with shadow_full: the shadow moves to main, shadow_full clears, idx=0, and the FSM stays in SEND. Gapless output, 8 cycles/frame.
  - Capture coinciding with acceptance of the idx==7 beat while the shadow is empty: the frame loads directly into main, idx=0, stay SEND.
  - The shadow is cleared on reset.
- Without the macro: single buffer and 9-cycle minimum as above. No shadow logic or storage is synthesized.

Test Plan:
- Frame sample k = (r=k+1, i=8'hF0+k) with in_valid=1 for one cycle and out_ready=1 -> starting the cycle after capture, 8 consecutive beats: out_r=1..8, out_i=F0..F7, out_idx=0..7, out_last only on idx 7, then out_valid=0.
- Same frame, out_ready low for 3 cycles at idx 2 -> out_r=3, out_i=F2, out_idx=2 held stable with out_valid=1 for all 3 cycles; sequence resumes with idx 3 and no sample lost or duplicated.
- Second frame offered at idx 4 of the first (no DBUF) -> in_ready=0, drop=1 next cycle, first frame completes unchanged, drop stays 1 until rst.
- rst low for one cycle at idx 5 -> next cycle out_valid=0, outputs 0, drop=0, in_ready=1; a new frame then streams from idx 0.
- FFT_OUT_DBUF_EN defined, frames A (r=8'h10+k) and B (r=8'h20+k) offered 1 cycle apart, out_ready=1 -> 16 gapless beats 10..17 then 20..27, out_last on beats 8 and 16, drop=0.
- FFT_OUT_DBUF_EN defined, frame offered exactly on the idx==7 accepted beat with shadow empty -> next cycle out_idx=0 with the new frame's sample 0, no idle gap.

Source files
------------

// File: rtl/fft_out_serializer.sv
// Captures one 8-point complex FFT frame per transfer and streams it one sample per beat over valid/ready.
// Define FFT_OUT_DBUF_EN to add a one-frame shadow buffer for gapless back-to-back frames.
module fft_out_serializer #(
    parameter int N = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [2**N-1:0]   in_0_r,
    input  logic signed [2**N-1:0]   in_1_r,
    input  logic signed [2**N-1:0]   in_2_r,
    input  logic signed [2**N-1:0]   in_3_r,
    input  logic signed [2**N-1:0]   in_4_r,
    input  logic signed [2**N-1:0]   in_5_r,
    input  logic signed [2**N-1:0]   in_6_r,
    input  logic signed [2**N-1:0]   in_7_r,
    input  logic signed [2**N-1:0]   in_0_i,
    input  logic signed [2**N-1:0]   in_1_i,
    input  logic signed [2**N-1:0]   in_2_i,
    input  logic signed [2**N-1:0]   in_3_i,
    input  logic signed [2**N-1:0]   in_4_i,
    input  logic signed [2**N-1:0]   in_5_i,
    input  logic signed [2**N-1:0]   in_6_i,
    input  logic signed [2**N-1:0]   in_7_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [2**N-1:0]   out_r,
    output logic signed [2**N-1:0]   out_i,
    output logic        [2:0]        out_idx,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     drop
);
    localparam int W = 2**N;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_d;
    logic [2:0]          idx, idx_d;
    logic                cap, acc, load_main;
    logic signed [W-1:0] in_r [8];
    logic signed [W-1:0] in_i [8];
    logic signed [W-1:0] frm_r_p1 [8];
    logic signed [W-1:0] frm_i_p1 [8];

    assign in_r[0] = in_0_r;  assign in_i[0] = in_0_i;
    assign in_r[1] = in_1_r;  assign in_i[1] = in_1_i;
    assign in_r[2] = in_2_r;  assign in_i[2] = in_2_i;
    assign in_r[3] = in_3_r;  assign in_i[3] = in_3_i;
    assign in_r[4] = in_4_r;  assign in_i[4] = in_4_i;
    assign in_r[5] = in_5_r;  assign in_i[5] = in_5_i;
    assign in_r[6] = in_6_r;  assign in_i[6] = in_6_i;
    assign in_r[7] = in_7_r;  assign in_i[7] = in_7_i;

    assign cap = in_valid & in_ready;
    assign acc = out_valid & out_ready;

`ifdef FFT_OUT_DBUF_EN
    logic signed [W-1:0] shd_r_p1 [8];
    logic signed [W-1:0] shd_i_p1 [8];
    logic                shd_full, shd_full_d, load_shd, move_shd;

    assign in_ready = rst & ~shd_full;
`else
    assign in_ready = rst & (state == IDLE);
`endif

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        load_main = 1'b0;
`ifdef FFT_OUT_DBUF_EN
        load_shd   = 1'b0;
        move_shd   = 1'b0;
        shd_full_d = shd_full;
`endif
        case (state)
            IDLE: begin
                if (cap) begin
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    load_main = 1'b1;
                end
            end
            SEND: begin
`ifdef FFT_OUT_DBUF_EN
                // On the final beat the next frame comes from the shadow first, else straight from the input.
                if (acc && idx == 3'd7) begin
                    idx_d = 3'd0;
                    if (shd_full) begin
                        move_shd   = 1'b1;
                        shd_full_d = 1'b0;
                    end else if (cap) begin
                        load_main = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (acc) idx_d = idx + 3'd1;
                    if (cap) begin
                        load_shd   = 1'b1;
                        shd_full_d = 1'b1;
                    end
                end
`else
                if (acc) begin
                    if (idx == 3'd7) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            drop  <= 1'b0;
`ifdef FFT_OUT_DBUF_EN
            shd_full <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            drop  <= drop | (in_valid & ~in_ready);
`ifdef FFT_OUT_DBUF_EN
            shd_full <= shd_full_d;
`endif
        end
    end

    // Stage p1: frame buffer(s), bit-exact copies of the input buses
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                frm_r_p1[k] <= '0;
                frm_i_p1[k] <= '0;
            end
        end else if (load_main) begin
            for (int k = 0; k < 8; k++) begin
                frm_r_p1[k] <= in_r[k];
                frm_i_p1[k] <= in_i[k];
            end
`ifdef FFT_OUT_DBUF_EN
        end else if (move_shd) begin
            for (int k = 0; k < 8; k++) begin
                frm_r_p1[k] <= shd_r_p1[k];
                frm_i_p1[k] <= shd_i_p1[k];
            end
`endif
        end
    end

`ifdef FFT_OUT_DBUF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                shd_r_p1[k] <= '0;
                shd_i_p1[k] <= '0;
            end
        end else if (load_shd) begin
            for (int k = 0; k < 8; k++) begin
                shd_r_p1[k] <= in_r[k];
                shd_i_p1[k] <= in_i[k];
            end
        end
    end
`endif

    assign out_valid = (state == SEND);
    assign out_r     = frm_r_p1[idx];
    assign out_i     = frm_i_p1[idx];
    assign out_idx   = idx;
    assign out_last  = (idx == 3'd7);

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: driver pushes expected beats on capture, monitor pops on accepted beats.
// Frame-level model: in_ready follows the number of beats still owed to the consumer.
module tb_fft_out_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] fr_r [8];
    logic [7:0] fr_i [8];
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_r, out_i;
    logic [2:0] out_idx;
    logic       out_last, out_valid, drop;
    logic       out_ready = 1'b0;

    always #5 clk = ~clk;

    fft_out_serializer #(.N(3)) dut (
        .clk(clk), .rst(rst),
        .in_0_r(fr_r[0]), .in_1_r(fr_r[1]), .in_2_r(fr_r[2]), .in_3_r(fr_r[3]),
        .in_4_r(fr_r[4]), .in_5_r(fr_r[5]), .in_6_r(fr_r[6]), .in_7_r(fr_r[7]),
        .in_0_i(fr_i[0]), .in_1_i(fr_i[1]), .in_2_i(fr_i[2]), .in_3_i(fr_i[3]),
        .in_4_i(fr_i[4]), .in_5_i(fr_i[5]), .in_6_i(fr_i[6]), .in_7_i(fr_i[7]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .drop(drop)
    );

`ifdef FFT_OUT_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] i;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    drop_exp = 1'b0;
    bit    was_rst  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_frame(input logic [7:0] rb, input logic [7:0] ib);
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = rb + 8'(k);
            fr_i[k] = ib + 8'(k);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = 8'($urandom);
            fr_i[k] = 8'($urandom);
        end
    endtask

    // One clock cycle: drive, check control against the model, then account for the coming edge.
    task automatic cycle(input bit v, input bit ordy, input bit r);
        bit exp_rdy, drop_nxt;
        int pending;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        rst       = r;
        #1;
        pending = exp_q.size();
        exp_rdy = r && (DBUF ? (pending <= 8) : (pending == 0));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, pending != 0);
        chk("drop", drop, drop_exp);
        if (was_rst) begin
            chk("rst_out_r", out_r, 0);
            chk("rst_out_i", out_i, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_out_last", out_last, 0);
        end
        if (v && exp_rdy) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back('{r: fr_r[k], i: fr_i[k], idx: 3'(k), last: (k == 7)});
        end
        drop_nxt = r ? (drop_exp | (v & !exp_rdy)) : 1'b0;
        @(posedge clk);
        #1;
        drop_exp = drop_nxt;
        was_rst  = !r;
        if (!r) exp_q.delete();
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            cycle(1'b0, 1'b1, 1'b1);
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare the presented beat every valid cycle; retire it when the consumer takes it.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got r=%0h i=%0h idx=%0d, expected no beat at %0t",
                             out_r, out_i, out_idx, $time);
                end else begin
                    b = exp_q[0];
                    chk("beat_r", out_r, b.r);
                    chk("beat_i", out_i, b.i);
                    chk("beat_idx", out_idx, b.idx);
                    chk("beat_last", out_last, b.last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_frame(8'h00, 8'h00);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 1);

        // Basic frame, consumer always ready
        set_frame(8'h01, 8'hF0);
        cycle(1, 1, 1);
        drain();
        cycle(0, 1, 1);

        // Back-pressure for 3 cycles on idx 2
        cycle(1, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        repeat (3) cycle(0, 0, 1);
        drain();
        cycle(0, 1, 1);

        // Second frame offered at idx 4
        set_frame(8'h01, 8'hF0);
        cycle(1, 1, 1);
        repeat (4) cycle(0, 1, 1);
        set_frame(8'h55, 8'hAA);
        cycle(1, 1, 1);
        set_frame(8'h66, 8'hBB);
        drain();
        repeat (2) cycle(0, 1, 1);

        // Reset in the middle of a frame at idx 5
        set_frame(8'h01, 8'hF0);
        cycle(1, 1, 1);
        repeat (5) cycle(0, 1, 1);
        cycle(0, 1, 0);
        set_frame(8'h31, 8'h41);
        cycle(1, 1, 1);
        drain();
        cycle(0, 1, 1);

`ifdef FFT_OUT_DBUF_EN
        // Two frames one cycle apart, expected gapless
        set_frame(8'h10, 8'h00);
        cycle(1, 1, 1);
        set_frame(8'h20, 8'h08);
        cycle(1, 1, 1);
        drain();
        cycle(0, 1, 1);

        // New frame offered on the accepted idx 7 beat with the shadow empty
        set_frame(8'h40, 8'h50);
        cycle(1, 1, 1);
        repeat (7) cycle(0, 1, 1);
        set_frame(8'h70, 8'h80);
        cycle(1, 1, 1);
        drain();
        cycle(0, 1, 1);
`endif

        // Randomized traffic with back-pressure and occasional reset
        for (int n = 0; n < 500; n++) begin
            rand_frame();
            cycle(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 90) != 0);
        end
        drain();
        cycle(0, 0, 0);
        cycle(0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
